// File: rtl/mul_frame_ctrl_if.sv
// Byte-stream handshake bundle for mul_frame_ctrl: receiver byte strobe in,
// transmitter request/data out. The controller connects to the slave modport.
interface mul_frame_ctrl_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic       tx_start;
   logic [7:0] tx_data;

   modport master (output rx_valid, output rx_data, output tx_ready,
                   input  tx_start, input  tx_data);
   modport slave  (input  rx_valid, input  rx_data, input  tx_ready,
                   output tx_start, output tx_data);
endinterface

// File: rtl/mul_frame_ctrl.sv
// Frame controller: gathers 2*NB operand bytes, runs an iterative shift-add multiply,
// streams the product back LSB first. Optional receive timeout: MUL_FRAME_CTRL_RX_TIMEOUT_EN.
module mul_frame_ctrl #(
   parameter int unsigned OP_WIDTH       = 8,
   parameter int unsigned DELAY_TIME     = 100,
   parameter int unsigned TX_GAP         = 100000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mul_enable,
   input  logic                  signed_mode,
   mul_frame_ctrl_if.slave       bus,
   output logic                  frames_received,
   output logic                  busy,
   output logic                  done,
   output logic [2*OP_WIDTH-1:0] product,
   output logic                  rx_error
);
   localparam int unsigned NB = OP_WIDTH / 8;
   localparam int unsigned PB = 2 * NB;

   function automatic int cw(input int unsigned bound);
      return $clog2(bound) + (((bound & (bound - 1)) == 0) ? 1 : 0);
   endfunction

   localparam int unsigned RXW = cw(PB);
   localparam int unsigned MCW = cw(OP_WIDTH);
   localparam int unsigned DW  = cw(DELAY_TIME);
   localparam int unsigned GW  = cw(TX_GAP);

   typedef enum logic [2:0] {
      S_IDLE, S_RX, S_DELAY, S_MUL, S_TX_LOAD, S_TX_WAIT, S_TX_GAP, S_DONE
   } state_t;

   state_t state, state_n;

   logic [RXW-1:0]        rx_count;
   logic [RXW-1:0]        tx_count;
   logic                  rx_valid_q;
   logic [8*PB-1:0]       rx_buf;
   logic [DW-1:0]         dly_cnt;
   logic [GW-1:0]         gap_cnt;
   logic [MCW-1:0]        mul_cnt;
   logic [2*OP_WIDTH-1:0] acc, mcand, acc_n, tx_shift;
   logic [OP_WIDTH-1:0]   mplier, op_a, op_b, mag_a, mag_b;
   logic                  neg, seen_fall;
   logic                  rx_edge, last_byte, timeout_hit;

   assign rx_edge   = bus.rx_valid & ~rx_valid_q;
   assign last_byte = (rx_count == RXW'(PB - 1));
   assign op_a      = rx_buf[OP_WIDTH-1:0];
   assign op_b      = rx_buf[2*OP_WIDTH-1:OP_WIDTH];
   assign mag_a     = (signed_mode && op_a[OP_WIDTH-1]) ? (~op_a + 1'b1) : op_a;
   assign mag_b     = (signed_mode && op_b[OP_WIDTH-1]) ? (~op_b + 1'b1) : op_b;
   assign acc_n     = acc + (mplier[0] ? mcand : '0);
   assign tx_shift  = product >> {tx_count, 3'b000};

   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign bus.tx_data = (state == S_TX_LOAD || state == S_TX_WAIT) ? tx_shift[7:0] : '0;

`ifdef MUL_FRAME_CTRL_RX_TIMEOUT_EN
   localparam int unsigned TW = cw(TIMEOUT_CYCLES);
   logic [TW-1:0] to_cnt;
   logic          to_run;

   // Timer only runs while a partial frame is pending and no byte arrives this cycle.
   assign to_run      = (state == S_RX) && mul_enable && !rx_edge && (rx_count != '0);
   assign timeout_hit = to_run && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt   <= '0;
         rx_error <= 1'b0;
      end else begin
         rx_error <= timeout_hit;
         if (to_run && !timeout_hit) to_cnt <= to_cnt + 1'b1;
         else                        to_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign rx_error    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n      = state;
      bus.tx_start = 1'b0;
      case (state)
         S_IDLE:    if (mul_enable) state_n = S_RX;
         S_RX: begin
            if (!mul_enable)
               state_n = S_IDLE;
            else if (rx_edge && last_byte)
               state_n = (DELAY_TIME == 0) ? S_MUL : S_DELAY;
         end
         S_DELAY:   if (dly_cnt == DW'(DELAY_TIME - 1)) state_n = S_MUL;
         S_MUL:     if (mul_cnt == MCW'(OP_WIDTH)) state_n = S_TX_LOAD;
         S_TX_LOAD: begin
            if (bus.tx_ready) begin
               bus.tx_start = 1'b1;
               state_n      = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            if (seen_fall && bus.tx_ready) begin
               if (tx_count == RXW'(PB - 1)) state_n = S_DONE;
               else                          state_n = (TX_GAP == 0) ? S_TX_LOAD : S_TX_GAP;
            end
         end
         S_TX_GAP:  if (gap_cnt == GW'(TX_GAP - 1)) state_n = S_TX_LOAD;
         S_DONE:    state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_valid_q      <= 1'b0;
         rx_count        <= '0;
         tx_count        <= '0;
         rx_buf          <= '0;
         dly_cnt         <= '0;
         gap_cnt         <= '0;
         mul_cnt         <= '0;
         acc             <= '0;
         mcand           <= '0;
         mplier          <= '0;
         neg             <= 1'b0;
         seen_fall       <= 1'b0;
         frames_received <= 1'b0;
         product         <= '0;
      end else begin
         rx_valid_q <= bus.rx_valid;
         case (state)
            S_IDLE: rx_count <= '0;
            S_RX: begin
               if (!mul_enable || timeout_hit) begin
                  rx_count <= '0;
               end else if (rx_edge) begin
                  for (int unsigned i = 0; i < PB; i++)
                     if (rx_count == RXW'(i)) rx_buf[8*i +: 8] <= bus.rx_data;
                  rx_count <= rx_count + 1'b1;
                  if (last_byte) frames_received <= 1'b1;
               end
            end
            S_DELAY: dly_cnt <= (dly_cnt == DW'(DELAY_TIME - 1)) ? '0 : dly_cnt + 1'b1;
            S_MUL: begin
               // Cycle 0 latches magnitudes and sign; cycles 1..OP_WIDTH add one partial product each.
               if (mul_cnt == '0) begin
                  neg    <= signed_mode & (op_a[OP_WIDTH-1] ^ op_b[OP_WIDTH-1]);
                  mcand  <= {{OP_WIDTH{1'b0}}, mag_a};
                  mplier <= mag_b;
                  acc    <= '0;
               end else begin
                  acc    <= acc_n;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
               if (mul_cnt == MCW'(OP_WIDTH)) begin
                  product  <= neg ? (~acc_n + 1'b1) : acc_n;
                  tx_count <= '0;
                  mul_cnt  <= '0;
               end else begin
                  mul_cnt <= mul_cnt + 1'b1;
               end
            end
            S_TX_WAIT: begin
               if (!bus.tx_ready) begin
                  seen_fall <= 1'b1;
               end else if (seen_fall) begin
                  seen_fall <= 1'b0;
                  tx_count  <= tx_count + 1'b1;
               end
            end
            S_TX_GAP: gap_cnt <= (gap_cnt == GW'(TX_GAP - 1)) ? '0 : gap_cnt + 1'b1;
            S_DONE:   frames_received <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/mul_frame_ctrl.md
Name: mul_frame_ctrl

Overview:
- Parametrised frame-level controller for the multiply core.
- Collects operand bytes from a byte-stream receiver (UART RX side) and computes the product with an internal iterative shift-add multiplier (signed or unsigned).
- Returns the product as a byte stream through a transmitter handshake (UART TX side), with a programmable inter-byte gap.
- Generalises the fixed 8x8, 2-frame flow to any OP_WIDTH that is a multiple of 8.

Parameters:
- OP_WIDTH, 8: bits per operand; must be a multiple of 8 and at least 8. Derived: NB = OP_WIDTH/8 bytes per operand, PB = 2*NB product bytes.
- DELAY_TIME, 100: cycles spent in DELAY between the last received byte and the start of the multiply.
- TX_GAP, 100000: idle cycles between transmitted product bytes; 0 skips the gap.
- TIMEOUT_CYCLES, 1000000: inter-byte receive timeout; used only with RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mul_enable  in  1  level; arms the controller
- signed_mode  in  1  1 = two's-complement operands; sampled on entry to MUL
- rx_valid  in  1  receiver byte-valid; a new byte is taken on its rising edge
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter idle
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_ready rises again
- frames_received  out  1  all 2*NB bytes captured; high until the block returns to IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entering DONE
- product  out  2*OP_WIDTH  last computed product; held until the next MUL completes
- rx_error  out  1  one-cycle pulse on receive timeout; constant 0 without RX_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE
  - all outputs = 0, including product
  - byte counters, delay counter, gap counter = 0
  - rx_valid edge register = 0
- State machine: IDLE, RX, DELAY, MUL, TX_LOAD, TX_WAIT, TX_GAP, DONE.
- IDLE:
  - mul_enable=1 -> RX next cycle; rx_count cleared.
- RX:
  - Byte order is little-endian: bytes 0..NB-1 form A (LSB first), bytes NB..2NB-1 form B.
  - Each rising edge of rx_valid stores rx_data into slot rx_count and increments rx_count.
  - On the last byte: frames_received <= 1, state -> DELAY.
  - rx_valid held high for many cycles counts as one byte.
  - mul_enable=0 while in RX discards the partial frame -> IDLE. Abort takes priority over a simultaneous byte edge.
  - After RX, mul_enable is ignored until DONE.
- DELAY:
  - Counts DELAY_TIME cycles, then -> MUL.
  - DELAY_TIME=0 goes straight to MUL.
- MUL:
  - Iterative shift-add, one partial product per cycle, OP_WIDTH cycles.
  - signed_mode=1: take operand magnitudes; negate the result if the operand signs differ. Full 2*OP_WIDTH result; -2^(N-1) * -2^(N-1) is exact.
  - Total latency from MUL entry to product update: OP_WIDTH+1 cycles.
  - On completion: product updated, tx_count = 0, -> TX_LOAD.
- TX_LOAD:
  - When tx_ready=1: tx_data = product byte tx_count (LSB first), tx_start = 1 for exactly one cycle, -> TX_WAIT.
  - Waits indefinitely while tx_ready=0.
- TX_WAIT:
  - First waits for tx_ready to fall (busy seen), then for it to rise again.
  - On the rise: tx_count++. If this was the last of PB bytes -> DONE; else -> TX_GAP.
  - A tx_ready that never falls leaves the block in TX_WAIT; only reset recovers.
- TX_GAP:
  - Counts TX_GAP cycles, then -> TX_LOAD.
  - Not entered after the last byte.
- DONE:
  - done pulses, frames_received <= 0, -> IDLE.
  - If mul_enable is still high, IDLE re-arms on the next cycle.
- Counter widths: $clog2 of each bound, plus 1 bit where the bound is a power of two. No wrap occurs within a legal run.
- Reset mid-operation (RX, MUL or TX) aborts immediately; the next frame starts clean.

Optional Feature:
- Macro: MUL_FRAME_CTRL_RX_TIMEOUT_EN.
- Defined:
  - In RX with rx_count > 0, a counter runs between byte edges.
  - Reaching TIMEOUT_CYCLES: rx_error pulses for one cycle, the partial frame is discarded, rx_count = 0, state stays RX.
  - The counter clears on every byte edge and on leaving RX.
- Undefined: no timeout counter is built, rx_error is tied 0, and partial frames wait indefinitely.

Test Plan:
- Basic unsigned frame:
  - Stimulus: OP_WIDTH=8, DELAY_TIME=4, TX_GAP=3; bytes 0x0F, 0x11.
  - Response: product=0x00FF; tx bytes 0xFF then 0x00; exactly 3 idle cycles between the first tx_ready rise and the second tx_start; done pulses once.
- Signed mode:
  - Stimulus: signed_mode=1, A=0xFF, B=0x02.
  - Response: product=0xFFFE.
  - Also A=0x80, B=0x80 -> 0x4000; unsigned 0x80*0x80 -> 0x4000; unsigned 0xFF*0xFF -> 0xFE01.
- Wide operands:
  - Stimulus: OP_WIDTH=16; bytes 0x34, 0x12, 0x02, 0x00.
  - Response: product=0x00002468; 4 tx bytes 0x68, 0x24, 0x00, 0x00; MUL latency 17 cycles.
- Abort and reset:
  - mul_enable dropped after 1 byte -> IDLE, busy=0, next frame is correct.
  - reset asserted in TX_WAIT -> all outputs 0 asynchronously.
- Handshake robustness:
  - rx_valid held high for 20 cycles counts as one byte.
  - tx_ready low for 50 cycles in TX_LOAD -> tx_start withheld until tx_ready rises.
- Timeout (macro defined):
  - Stimulus: TIMEOUT_CYCLES=50; 1 byte, then silence for 60 cycles.
  - Response: rx_error pulse at cycle 50; the next two bytes form a fresh frame.
